game_datapath: RTL and testbench

//  Datapath for the single-player paddle game; responder to the game control FSM. Consumes its

---
 rtl/game_datapath.sv | 187 ++++++++++++++++++
 tb/tb_game_datapath.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_datapath.sv
// Paddle/ball datapath for the single-player paddle game: frame tick, a four-state step
// sequencer (IDLE/PADDLE/BALL/HIT), paddle and ball motion, hit/miss detection and score.
module game_datapath #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int PADDLE_H = 16,
    parameter int PADDLE_X = 4,
    parameter int TICK_DIV = 833333,
    parameter int SCORE_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reset_co,
    input  logic               move_ball,
    input  logic               rd_ld,
    input  logic               reset_movement,
    input  logic               paddle_up,
    input  logic               paddle_down,
    output logic [7:0]         ball_x,
    output logic [6:0]         ball_y,
    output logic [6:0]         paddle_y,
    output logic [SCORE_W-1:0] score,
    output logic               miss,
    output logic               over,
    output logic               busy
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [7:0]         X_RST     = 8'(SCREEN_W / 2);
    localparam logic [7:0]         X_MAX     = 8'(SCREEN_W - 1);
    localparam logic [7:0]         X_HIT     = 8'(PADDLE_X + 1);
    localparam logic [6:0]         Y_RST     = 7'(SCREEN_H / 2);
    localparam logic [6:0]         Y_MAX     = 7'(SCREEN_H - 1);
    localparam logic [6:0]         P_RST     = 7'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [6:0]         P_MAX     = 7'(SCREEN_H - PADDLE_H);
    localparam logic [7:0]         P_SPAN    = 8'(PADDLE_H - 1);
    localparam logic [CW-1:0]      CNT_MAX   = CW'(TICK_DIV - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PADDLE,
        S_BALL,
        S_HIT
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7:0]         ball_x_q, ball_x_d;
    logic [6:0]         ball_y_q, ball_y_d;
    logic [6:0]         paddle_y_q, paddle_y_d;
    logic               dx_neg_q, dx_neg_d;   // 1: moving toward x=0
    logic               dy_neg_q, dy_neg_d;   // 1: moving toward y=0
    logic [SCORE_W-1:0] score_q, score_d;
    logic               miss_q, miss_d;
    logic               over_q, over_d;

    logic               tick;
    logic               dx_ref, dy_ref;
    logic               in_paddle;

    assign tick = (cnt_q == CNT_MAX);

    // Vertical overlap with the paddle, evaluated one bit wider so the bottom edge cannot wrap.
    assign in_paddle = (ball_y_q >= paddle_y_q) &&
                       ({1'b0, ball_y_q} <= ({1'b0, paddle_y_q} + P_SPAN));

    always_comb begin
        state_d    = state_q;
        cnt_d      = tick ? '0 : cnt_q + CW'(1);
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        paddle_y_d = paddle_y_q;
        dx_neg_d   = dx_neg_q;
        dy_neg_d   = dy_neg_q;
        score_d    = score_q;
        miss_d     = 1'b0;
        over_d     = over_q;
        dx_ref     = dx_neg_q;
        dy_ref     = dy_neg_q;

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_PADDLE;
                end
            end
            S_PADDLE: begin
                state_d = S_BALL;
                if (rd_ld) begin
                    if (paddle_up && !paddle_down && (paddle_y_q != 7'd0)) begin
                        paddle_y_d = paddle_y_q - 7'd1;
                    end else if (paddle_down && !paddle_up && (paddle_y_q < P_MAX)) begin
                        paddle_y_d = paddle_y_q + 7'd1;
                    end
                end
            end
            S_BALL: begin
                state_d = S_HIT;
                if (move_ball && !over_q) begin
                    // Reflect on the current position first, then step with the new direction.
                    if (ball_y_q == 7'd0) begin
                        dy_ref = 1'b0;
                    end else if (ball_y_q == Y_MAX) begin
                        dy_ref = 1'b1;
                    end
                    if (ball_x_q == X_MAX) begin
                        dx_ref = 1'b1;
                    end
                    dx_neg_d = dx_ref;
                    dy_neg_d = dy_ref;
                    ball_x_d = dx_ref ? ball_x_q - 8'd1 : ball_x_q + 8'd1;
                    ball_y_d = dy_ref ? ball_y_q - 7'd1 : ball_y_q + 7'd1;
                end
            end
            S_HIT: begin
                state_d = S_IDLE;
                if (dx_neg_q && (ball_x_q == X_HIT) && in_paddle) begin
                    dx_neg_d = 1'b0;
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end else if ((ball_x_q == 8'd0) && !over_q) begin
                    miss_d = 1'b1;
                    over_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Movement reinit abandons any sequence in flight, including its score update.
        if (!reset_movement) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            ball_x_d   = X_RST;
            ball_y_d   = Y_RST;
            paddle_y_d = P_RST;
            dx_neg_d   = 1'b1;
            dy_neg_d   = 1'b0;
            score_d    = score_q;
            miss_d     = 1'b0;
            over_d     = 1'b0;
        end

        if (!reset_co) begin
            score_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ball_x_q   <= X_RST;
            ball_y_q   <= Y_RST;
            paddle_y_q <= P_RST;
            dx_neg_q   <= 1'b1;
            dy_neg_q   <= 1'b0;
            score_q    <= '0;
            miss_q     <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            paddle_y_q <= paddle_y_d;
            dx_neg_q   <= dx_neg_d;
            dy_neg_q   <= dy_neg_d;
            score_q    <= score_d;
            miss_q     <= miss_d;
            over_q     <= over_d;
        end
    end

    assign ball_x   = ball_x_q;
    assign ball_y   = ball_y_q;
    assign paddle_y = paddle_y_q;
    assign score    = score_q;
    assign miss     = miss_q;
    assign over     = over_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_game_datapath.sv
// Bench for game_datapath: directed reset/reinit checks, then randomized frames scored against
// a per-frame reference model through an expectation queue drained by a separate monitor.
module tb_game_datapath;

    localparam int TICK_DIV = 4;
    localparam int SCORE_W  = 3;
    localparam int SMAX     = 7;
    localparam int NFRAMES  = 6000;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               reset_co = 1'b1;
    logic               move_ball = 1'b0;
    logic               rd_ld = 1'b0;
    logic               reset_movement = 1'b1;
    logic               paddle_up = 1'b0;
    logic               paddle_down = 1'b0;
    logic [7:0]         ball_x;
    logic [6:0]         ball_y;
    logic [6:0]         paddle_y;
    logic [SCORE_W-1:0] score;
    logic               miss;
    logic               over;
    logic               busy;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int bx;
        int by;
        int py;
        int score;
        int over;
        int misses;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: plain integers, directions as +1/-1.
    int m_bx, m_by, m_dx, m_dy, m_py, m_score, m_over;

    always #5 clk = ~clk;

    game_datapath #(
        .SCREEN_W(160), .SCREEN_H(120), .PADDLE_H(16), .PADDLE_X(4),
        .TICK_DIV(TICK_DIV), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .reset(reset), .reset_co(reset_co), .move_ball(move_ball),
        .rd_ld(rd_ld), .reset_movement(reset_movement), .paddle_up(paddle_up),
        .paddle_down(paddle_down), .ball_x(ball_x), .ball_y(ball_y),
        .paddle_y(paddle_y), .score(score), .miss(miss), .over(over), .busy(busy)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_reinit();
        m_bx = 80; m_by = 60; m_dx = -1; m_dy = 1; m_py = 52; m_over = 0;
    endtask

    task automatic model_frame(input bit up, input bit dn, input bit rl, input bit mb,
                               input bit rc, output exp_t e);
        int misses;
        misses = 0;
        if (rl) begin
            if (up && !dn && m_py > 0) m_py = m_py - 1;
            else if (dn && !up && m_py < 104) m_py = m_py + 1;
        end
        if (mb && m_over == 0) begin
            if (m_by == 0) m_dy = 1;
            if (m_by == 119) m_dy = -1;
            if (m_bx == 159) m_dx = -1;
            m_bx = m_bx + m_dx;
            m_by = m_by + m_dy;
        end
        if (m_dx == -1 && m_bx == 5 && m_by >= m_py && m_by <= m_py + 15) begin
            m_dx = 1;
            if (rc && m_score < SMAX) m_score = m_score + 1;
        end else if (m_bx == 0 && m_over == 0) begin
            misses = 1;
            m_over = 1;
        end
        if (!rc) m_score = 0;
        e.bx = m_bx; e.by = m_by; e.py = m_py;
        e.score = m_score; e.over = m_over; e.misses = misses;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ball_x"}, int'(ball_x), 80);
        chk({tag, "_ball_y"}, int'(ball_y), 60);
        chk({tag, "_paddle_y"}, int'(paddle_y), 52);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_miss"}, int'(miss), 0);
        chk({tag, "_over"}, int'(over), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (n < 20 && !busy) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_frame(output bit ok);
        int n;
        n = 0;
        while (n < 20 && !busy) begin
            @(negedge clk);
            n++;
        end
        while (n < 20 && busy) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 20);
    endtask

    initial begin : monitor
        bit   prev_busy;
        int   miss_seen;
        int   frame;
        exp_t e;
        prev_busy = 1'b0;
        miss_seen = 0;
        frame = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (miss) miss_seen++;
                if (prev_busy && !busy) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_frame", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_ball_x", int'(ball_x), e.bx);
                        chk("sb_ball_y", int'(ball_y), e.by);
                        chk("sb_paddle_y", int'(paddle_y), e.py);
                        chk("sb_score", int'(score), e.score);
                        chk("sb_over", int'(over), e.over);
                        chk("sb_miss_pulses", miss_seen, e.misses);
                        $display("frame %0d ball=(%0d,%0d) paddle=%0d score=%0d over=%0d miss=%0d",
                                 frame, ball_x, ball_y, paddle_y, score, over, miss_seen);
                    end
                    frame++;
                    miss_seen = 0;
                end
            end
            prev_busy = busy;
        end
    end

    initial begin : stimulus
        int   n;
        int   mode;
        bit   ok;
        bit   up, dn, rl, mb, rc;
        exp_t e;

        // Reset values
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("rst");

        // First free-flight step, then async reset while in HIT
        move_ball = 1'b1;
        wait_busy(n);
        chk("t1_busy_seen", int'(busy), 1);
        @(negedge clk);
        @(negedge clk);
        chk("t2_step_x", int'(ball_x), 79);
        chk("t2_step_y", int'(ball_y), 61);
        chk("t1_busy_in_hit", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("rst_mid");
        @(negedge clk);
        reset = 1'b0;

        // Movement reinit while in BALL, then tick counter restarts from 0
        wait_busy(n);
        chk("t6_busy_seen", int'(busy), 1);
        @(negedge clk);
        reset_movement = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_ball_x", int'(ball_x), 80);
        chk("t6_ball_y", int'(ball_y), 60);
        chk("t6_paddle_y", int'(paddle_y), 52);
        @(negedge clk);
        reset_movement = 1'b1;
        wait_busy(n);
        chk("t6_tick_latency", n, 4);

        // Randomized frames
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        move_ball = 1'b0;
        model_reinit();
        m_score = 0;
        mon_en = 1'b1;
        mode = 0;
        for (int f = 0; f < NFRAMES; f++) begin
            if (f % 300 == 0) mode = $urandom_range(0, 9);
            if ((m_over != 0 && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) begin
                reset_movement = 1'b0;
                @(negedge clk);
                reset_movement = 1'b1;
                model_reinit();
            end
            if (mode <= 5) begin
                up = (m_py + 8 > m_by + 1);
                dn = (m_py + 8 < m_by - 1);
            end else if (mode == 6) begin
                up = 1'b1; dn = 1'b0;
            end else if (mode == 7) begin
                up = 1'b0; dn = 1'b1;
            end else if (mode == 8) begin
                up = 1'b1; dn = 1'b1;
            end else begin
                up = 1'($urandom_range(0, 1));
                dn = 1'($urandom_range(0, 1));
            end
            rl = ($urandom_range(0, 19) != 0);
            mb = ($urandom_range(0, 19) != 0);
            rc = ($urandom_range(0, 999) != 0);
            paddle_up = up;
            paddle_down = dn;
            rd_ld = rl;
            move_ball = mb;
            reset_co = rc;
            model_frame(up, dn, rl, mb, rc, e);
            exp_q.push_back(e);
            wait_frame(ok);
            if (!ok) begin
                chk("frame_timeout", 0, 1);
                break;
            end
        end
        repeat (3) @(negedge clk);
        chk("sb_leftover", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
